// File: rtl/plic_lite_pkg.sv
// Shared constants and types for the lightweight PLIC.
// Register offsets are reserved here for the future bus wrapper.
package plic_lite_pkg;

    localparam int PLIC_NO_IRQ_ID      = 0;
    localparam int PLIC_DEFAULT_PRIO_W = 3;

    localparam logic [31:0] PLIC_OFF_PRIORITY  = 32'h0000_0000;
    localparam logic [31:0] PLIC_OFF_PENDING   = 32'h0000_1000;
    localparam logic [31:0] PLIC_OFF_ENABLE    = 32'h0000_2000;
    localparam logic [31:0] PLIC_OFF_THRESHOLD = 32'h0020_0000;
    localparam logic [31:0] PLIC_OFF_CLAIM     = 32'h0020_0004;

    typedef enum logic {
        SRC_LEVEL = 1'b0,
        SRC_EDGE  = 1'b1
    } src_mode_e;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: synchroniser, edge detect, and the
// pending / in-service / held-edge bookkeeping for one source.
module plic_gateway
    import plic_lite_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_service
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_prev;
    logic                   rise;
    logic                   idle;
    logic                   edge_held;
    logic                   pending_d;
    logic                   in_service_d;
    logic                   edge_held_d;
    src_mode_e              mode;

    assign mode = src_mode_e'(edge_mode);
    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev;
    assign idle = ~pending & ~in_service;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q[0] <= irq;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_prev <= s;
        end
    end

    // A claim only takes effect on a source that is really pending, so a stale
    // best_id from back-to-back claims can never put an idle source in service.
    always_comb begin
        pending_d    = pending;
        in_service_d = in_service;
        edge_held_d  = edge_held;
        if (claim && pending) begin
            pending_d    = 1'b0;
            in_service_d = 1'b1;
        end else if (idle) begin
            if (mode == SRC_EDGE) begin
                if (edge_held) begin
                    pending_d   = 1'b1;
                    edge_held_d = 1'b0;
                end else if (rise) begin
                    pending_d = 1'b1;
                end
            end else if (s) begin
                pending_d = 1'b1;
            end
        end
        if (!idle && (mode == SRC_EDGE) && rise) begin
            edge_held_d = 1'b1;
        end
        if (complete && in_service) begin
            in_service_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            in_service <= 1'b0;
            edge_held  <= 1'b0;
        end else begin
            pending    <= pending_d;
            in_service <= in_service_d;
            edge_held  <= edge_held_d;
        end
    end

endmodule

// File: rtl/plic_lite.sv
// Platform-level interrupt controller: per-source gateways, a priority
// arbiter with lowest-ID tie break, and the claim/complete handshake.
module plic_lite
    import plic_lite_pkg::*;
#(
    parameter  int NUM_SRC     = 16,
    parameter  int PRIO_W      = PLIC_DEFAULT_PRIO_W,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic [NUM_SRC-1:0]        src_edge,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim_req,
    output logic                      claim_valid,
    output logic [ID_W-1:0]           claim_id,
    input  logic                      complete_req,
    input  logic [ID_W-1:0]           complete_id,
    output logic                      ext_irq
);

    localparam logic [ID_W-1:0] NO_ID = ID_W'(PLIC_NO_IRQ_ID);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] complete_hit;
    logic [PRIO_W-1:0]  prio_arr [NUM_SRC];

    logic [ID_W-1:0]    best_id;
    logic [PRIO_W-1:0]  best_prio;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic               claim_live;

    // best_prio is nonzero exactly when best_id names a real winner.
    assign claim_live = claim_req && (best_prio != '0);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign prio_arr[i]     = src_prio[i*PRIO_W +: PRIO_W];
        assign eligible[i]     = pending[i] && src_en[i] && (prio_arr[i] > threshold);
        assign claim_hit[i]    = claim_live && (best_id == ID_W'(i + 1));
        assign complete_hit[i] = complete_req && (complete_id == ID_W'(i + 1));

        plic_gateway #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_gateway (
            .clk        (clk),
            .rst_n      (rst_n),
            .irq        (src_irq[i]),
            .edge_mode  (src_edge[i]),
            .claim      (claim_hit[i]),
            .complete   (complete_hit[i]),
            .pending    (pending[i]),
            .in_service (in_service[i])
        );
    end

    // Strict greater-than while scanning upward keeps the lowest ID on ties.
    always_comb begin
        win_id   = NO_ID;
        win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (prio_arr[i] > win_prio)) begin
                win_id   = ID_W'(i + 1);
                win_prio = prio_arr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_id     <= NO_ID;
            best_prio   <= '0;
            ext_irq     <= 1'b0;
            claim_valid <= 1'b0;
            claim_id    <= NO_ID;
        end else begin
            best_id     <= win_id;
            best_prio   <= win_prio;
            ext_irq     <= (win_id != NO_ID);
            claim_valid <= claim_req;
            claim_id    <= claim_live ? best_id : NO_ID;
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Self-checking bench for plic_lite: a table of arbitration vectors plus
// hand-written sequences for latency, handshake and reset corner cases.
module tb_plic_lite;

    localparam int NUM_SRC = 16;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = 5;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        src_irq;
    logic [NUM_SRC-1:0]        src_edge;
    logic [NUM_SRC-1:0]        src_en;
    logic [NUM_SRC*PRIO_W-1:0] src_prio;
    logic [PRIO_W-1:0]         threshold;
    logic                      claim_req;
    logic                      claim_valid;
    logic [ID_W-1:0]           claim_id;
    logic                      complete_req;
    logic [ID_W-1:0]           complete_id;
    logic                      ext_irq;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string           name;
        logic [15:0]     irq;
        logic [15:0]     en;
        logic [2:0]      thr;
        logic [47:0]     prio;
        logic            exp_irq;
        logic [ID_W-1:0] exp_id;
    } vec_t;

    vec_t vecs [10];

    plic_lite #(
        .NUM_SRC     (NUM_SRC),
        .PRIO_W      (PRIO_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_irq      (src_irq),
        .src_edge     (src_edge),
        .src_en       (src_en),
        .src_prio     (src_prio),
        .threshold    (threshold),
        .claim_req    (claim_req),
        .claim_valid  (claim_valid),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .ext_irq      (ext_irq)
    );

    always #5 clk = ~clk;

    // All priorities default to 1; up to three (ID, prio) overrides, ID 0 unused.
    function automatic logic [47:0] mk_prio(int ia, int pa, int ib, int pb, int ic, int pc);
        logic [47:0] p;
        for (int i = 0; i < NUM_SRC; i++) p[i*3 +: 3] = 3'd1;
        if (ia != 0) p[(ia-1)*3 +: 3] = 3'(pa);
        if (ib != 0) p[(ib-1)*3 +: 3] = 3'(pb);
        if (ic != 0) p[(ic-1)*3 +: 3] = 3'(pc);
        return p;
    endfunction

    function automatic vec_t mkv(string name, logic [15:0] irq, logic [15:0] en, logic [2:0] thr,
                                 logic [47:0] prio, logic exp_irq, logic [ID_W-1:0] exp_id);
        vec_t v;
        v.name = name; v.irq = irq; v.en = en; v.thr = thr;
        v.prio = prio; v.exp_irq = exp_irq; v.exp_id = exp_id;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        src_irq      = '0;
        src_edge     = '0;
        src_en       = '1;
        src_prio     = mk_prio(0, 0, 0, 0, 0, 0);
        threshold    = '0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_claim(input string name, input logic [ID_W-1:0] exp_id);
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        checkOutput({name, "_valid"}, 32'(claim_valid), 32'd1);
        checkOutput({name, "_id"}, 32'(claim_id), 32'(exp_id));
    endtask

    task automatic do_complete(input logic [ID_W-1:0] id);
        complete_req = 1'b1;
        complete_id  = id;
        tick();
        complete_req = 1'b0;
        complete_id  = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        do_reset();
        src_en    = v.en;
        threshold = v.thr;
        src_prio  = v.prio;
        src_irq   = v.irq;
        repeat (6) tick();
        checkOutput({v.name, "_ext_irq"}, 32'(ext_irq), 32'(v.exp_irq));
        do_claim(v.name, v.exp_id);
    endtask

    initial begin
        int bad;

        vecs[0] = mkv("idle",        16'h0000, 16'hFFFF, 3'd0, mk_prio(0,0,0,0,0,0),  1'b0, 5'd0);
        vecs[1] = mkv("prio_win",    16'h0142, 16'hFFFF, 3'd0, mk_prio(2,2,7,5,9,5),  1'b1, 5'd7);
        vecs[2] = mkv("thr_block",   16'h0142, 16'hFFFF, 3'd5, mk_prio(2,2,7,5,9,5),  1'b0, 5'd0);
        vecs[3] = mkv("thr_pass",    16'h0142, 16'hFFFF, 3'd4, mk_prio(2,2,7,5,9,5),  1'b1, 5'd7);
        vecs[4] = mkv("en_hide7",    16'h0142, 16'hFFBF, 3'd0, mk_prio(2,2,7,5,9,5),  1'b1, 5'd9);
        vecs[5] = mkv("en_off3",     16'h0004, 16'hFFFB, 3'd0, mk_prio(0,0,0,0,0,0),  1'b0, 5'd0);
        vecs[6] = mkv("prio_zero",   16'h0004, 16'hFFFF, 3'd0, mk_prio(3,0,0,0,0,0),  1'b0, 5'd0);
        vecs[7] = mkv("tie_low_id",  16'h8001, 16'hFFFF, 3'd0, mk_prio(0,0,0,0,0,0),  1'b1, 5'd1);
        vecs[8] = mkv("high_id16",   16'h8001, 16'hFFFF, 3'd0, mk_prio(16,7,1,1,0,0), 1'b1, 5'd16);
        vecs[9] = mkv("thr1_id4",    16'h0009, 16'hFFFF, 3'd1, mk_prio(4,2,0,0,0,0),  1'b1, 5'd4);

        do_reset();
        checkOutput("reset_ext_irq", 32'(ext_irq), 32'd0);
        checkOutput("reset_claim_valid", 32'(claim_valid), 32'd0);
        checkOutput("reset_claim_id", 32'(claim_id), 32'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Successive claims drain in priority order with lowest ID on ties.
        do_reset();
        src_prio = mk_prio(2, 2, 7, 5, 9, 5);
        src_irq  = 16'h0142;
        repeat (6) tick();
        do_claim("drain_a", 5'd7);
        tick();
        do_claim("drain_b", 5'd9);
        tick();
        do_claim("drain_c", 5'd2);
        tick();
        checkOutput("drain_empty", 32'(ext_irq), 32'd0);

        // Edge mode: latency, claim removal, held edge re-pends after complete.
        do_reset();
        src_edge = 16'h0010;
        src_prio = mk_prio(5, 3, 0, 0, 0, 0);
        src_irq[4] = 1'b1;
        repeat (3) tick();
        checkOutput("edge_lat_early", 32'(ext_irq), 32'd0);
        tick();
        checkOutput("edge_lat", 32'(ext_irq), 32'd1);
        do_claim("edge_claim", 5'd5);
        tick();
        checkOutput("edge_claim_drop", 32'(ext_irq), 32'd0);
        checkOutput("claim_pulse", 32'(claim_valid), 32'd0);
        src_irq[4] = 1'b0;
        repeat (3) tick();
        src_irq[4] = 1'b1;
        repeat (4) tick();
        checkOutput("edge_held_quiet", 32'(ext_irq), 32'd0);
        do_complete(5'd5);
        repeat (2) tick();
        checkOutput("edge_repend", 32'(ext_irq), 32'd1);
        do_claim("edge_reclaim", 5'd5);

        // Level mode: re-pends while held, not after the line drops.
        do_reset();
        src_irq[2] = 1'b1;
        repeat (5) tick();
        checkOutput("level_irq", 32'(ext_irq), 32'd1);
        do_claim("level_claim", 5'd3);
        repeat (2) tick();
        checkOutput("level_in_service", 32'(ext_irq), 32'd0);
        do_complete(5'd3);
        repeat (2) tick();
        checkOutput("level_repend", 32'(ext_irq), 32'd1);
        do_claim("level_reclaim", 5'd3);
        src_irq[2] = 1'b0;
        repeat (4) tick();
        do_complete(5'd3);
        repeat (4) tick();
        checkOutput("level_no_repend", 32'(ext_irq), 32'd0);

        // Disabling hides a source but keeps it pending.
        do_reset();
        src_en = 16'hFFFB;
        src_irq[2] = 1'b1;
        repeat (6) tick();
        checkOutput("mask_hidden", 32'(ext_irq), 32'd0);
        src_irq[2] = 1'b0;
        repeat (4) tick();
        src_en = 16'hFFFF;
        repeat (2) tick();
        checkOutput("mask_kept", 32'(ext_irq), 32'd1);
        do_claim("mask_kept", 5'd3);

        // Simultaneous complete(5) and claim(7), then bogus completes.
        do_reset();
        src_edge = 16'h0010;
        src_prio = mk_prio(5, 5, 7, 3, 0, 0);
        src_irq  = 16'h0050;
        repeat (6) tick();
        do_claim("sim_first", 5'd5);
        tick();
        src_irq[4] = 1'b0;
        repeat (3) tick();
        src_irq[4] = 1'b1;
        repeat (4) tick();
        claim_req    = 1'b1;
        complete_req = 1'b1;
        complete_id  = 5'd5;
        tick();
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;
        checkOutput("sim_claim_id", 32'(claim_id), 32'd7);
        repeat (3) tick();
        checkOutput("sim_complete_repend", 32'(ext_irq), 32'd1);
        do_claim("sim_second", 5'd5);
        repeat (2) tick();
        do_complete(5'd0);
        do_complete(5'd17);
        repeat (3) tick();
        checkOutput("bad_complete", 32'(ext_irq), 32'd0);
        do_complete(5'd7);
        repeat (3) tick();
        checkOutput("good_complete", 32'(ext_irq), 32'd1);

        // Asynchronous reset with a claim in flight.
        claim_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ext_irq", 32'(ext_irq), 32'd0);
        checkOutput("rst_mid_claim_id", 32'(claim_id), 32'd0);
        tick();
        checkOutput("rst_mid_claim_valid", 32'(claim_valid), 32'd0);
        claim_req = 1'b0;
        rst_n = 1'b1;

        // Random traffic: outputs never X, claim_id never out of range.
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            src_irq      = 16'($urandom);
            src_edge     = 16'($urandom);
            src_en       = 16'($urandom);
            src_prio     = {16'($urandom), 32'($urandom)};
            threshold    = 3'($urandom_range(0, 3));
            claim_req    = 1'($urandom);
            complete_req = 1'($urandom);
            complete_id  = 5'($urandom_range(0, 20));
            tick();
            if ($isunknown({ext_irq, claim_valid, claim_id}) || (claim_id > 5'd16)) bad++;
        end
        claim_req    = 1'b0;
        complete_req = 1'b0;
        checkOutput("random_outputs", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
Parametrised platform-level interrupt controller that aggregates NUM_SRC peripheral interrupt sources into a single machine external interrupt line.
- Supports per-source priority, enable, edge/level mode and a global priority threshold.
- Uses a claim/complete handshake so software can identify and retire the winning source.
- ext_irq drives the external_int input of the core's interrupt_controller. MCAUSE 11 remains the architectural cause; the claimed ID identifies the source.

Parameters:
NUM_SRC, 16, number of interrupt sources (1..63); source i has ID i+1, ID 0 means "none".
PRIO_W, 3, priority field width; priority 0 means never interrupt.
SYNC_STAGES, 2, synchroniser flops per source input (>=1).
ID_W (localparam), $clog2(NUM_SRC+1), width of claim/complete IDs.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
src_irq  input  NUM_SRC  raw asynchronous source lines.
src_edge  input  NUM_SRC  per-source mode: 1 = rising edge, 0 = active-high level.
src_en  input  NUM_SRC  per-source enable.
src_prio  input  NUM_SRC*PRIO_W  flat priorities; source i is bits [i*PRIO_W +: PRIO_W].
threshold  input  PRIO_W  only priorities strictly greater than this interrupt.
claim_req  input  1  one-cycle claim strobe.
claim_valid  output  1  one-cycle pulse, the cycle after claim_req.
claim_id  output  ID_W  claimed ID, valid with claim_valid; 0 if nothing was eligible.
complete_req  input  1  one-cycle completion strobe.
complete_id  input  ID_W  ID being retired.
ext_irq  output  1  registered; high while an eligible source exists.

Behaviour:
- Reset: all sync flops, pending, in_service, edge_held, best_id and best_prio clear to 0. claim_valid=0, claim_id=0, ext_irq=0.
- Synchroniser: SYNC_STAGES flops per source produce s[i]. Edge mode keeps a previous-value flop and detects rise = s & ~s_prev.
- Gateway, per source, when not pending and not in_service:
  - edge mode: a rise sets pending;
  - level mode: s=1 sets pending.
- Gateway while pending or in_service:
  - edge mode: a rise sets the one-deep edge_held flag; further edges are dropped;
  - level mode: the input is ignored.
- After complete:
  - edge mode: edge_held re-pends the source on the next cycle and clears;
  - level mode: the source re-pends if s is still 1.
- pending is not gated by src_en. Disabling a source hides it from arbitration but keeps it pending.
- Eligibility: pending & src_en & (prio > threshold).
- Arbitration: highest priority wins; ties go to the lowest ID. The winner is registered into best_id/best_prio each cycle, with best_id=0 if nothing is eligible.
- ext_irq is registered as (best_id != 0).
- Latency from the src_irq rising edge to ext_irq=1: SYNC_STAGES+2 cycles (sync, pending, arbiter register).
- Claim: on claim_req, the next cycle drives claim_valid=1 and claim_id=best_id. If best_id!=0, that source's pending clears and in_service sets in the same edge, and ext_irq reflects the removal one cycle later. A claim with best_id=0 returns 0 and changes no state.
- Complete: clears in_service[complete_id-1] when set. complete_id of 0, an out-of-range value, or a source not in service is ignored silently.
- Simultaneous claim and complete in the same cycle are both applied. Completing X while claiming Y is legal. If X==Y, the claim is impossible because an in-service source is never pending.
- Changing src_edge, src_prio or threshold takes effect on the next arbitration cycle. A mode change does not clear pending or in_service.
- An asynchronous reset mid-handshake clears everything immediately. A claim_req in flight produces no claim_valid.
- ext_irq has no internal gating by mstatus.MIE; the core masks it.

Decomposition:
- Shared package / riscv_defines.vh gets the ID-0 "no interrupt" constant, the default PRIO_W, and the PLIC register offsets (priority, enable, threshold, claim/complete) for the later bus wrapper.
- One natural sub-module, plic_gateway: one instance per source via generate. It holds the synchroniser, edge detect, pending, in_service and edge_held.
- The arbiter is a combinational loop in the top level plus its output registers.

Test Plan:
- Reset/idle: NUM_SRC=16, all prio=1, threshold=0, no sources -> ext_irq=0; claim returns claim_valid=1, claim_id=0.
- Edge latency/claim/complete: source 4 (ID 5) edge mode, prio 3, rise on src_irq -> ext_irq=1 exactly SYNC_STAGES+2 cycles later. Claim -> claim_id=5, ext_irq=0 one cycle later. A second rise during service, then complete_id=5 -> re-pends, ext_irq=1 again.
- Priority/ties: IDs 2 (prio 2), 7 (prio 5), 9 (prio 5) pending -> successive claims return 7, 9, 2. threshold=5 -> ext_irq=0 and claim_id=0.
- Level mode: ID 3 level, held high, claimed and completed -> re-pends immediately. Dropped before complete -> no re-pend.
- Masking: src_en[2]=0 with ID 3 pending -> ext_irq=0. Re-enable -> ext_irq=1 with pending kept. prio=0 -> never interrupts.
- Robustness: simultaneous complete_id=5 and claim of ID 7 both take effect. complete_id=0 or 17 -> no state change. Assert rst_n mid-claim -> all outputs 0 with no claim_valid. 200 random cycles -> no X on outputs, and claim_id is always 0 or an in-range ID.
